// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and the default pointer width.
// Latency: none, pure functions and constants.
// Backpressure: not applicable.
package fifo_pkg;

  // Default log2 depth, shared by the write- and read-side controllers.
  localparam int ADDR_WIDTH_DFLT = 4;

  // Functions work on a wide word; callers zero-extend in and truncate out,
  // which keeps them usable for any pointer width up to GW bits.
  localparam int GW = 32;
  typedef logic [GW-1:0] gword_t;

  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b = '0;
    for (int i = 0; i < GW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle between the FIFO write client/read domain and the pointer controller.
// Latency: none, wiring only.
// Backpressure: wfull gates writes; wen tells the memory which requests landed.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DFLT
);
  logic                  winc;
  logic                  wovf_clr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  wovf;

  // Client / environment side.
  modport master (
    output winc, wovf_clr, rptr,
    input  waddr, wen, wptr, wfull, walmost_full, wlevel, wovf
  );

  // Controller side.
  modport slave (
    input  winc, wovf_clr, rptr,
    output waddr, wen, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/fifo_wptr_full_sync_r2w.sv
// Two-flop synchroniser bringing the Gray read pointer into wclk.
// Latency: 2 wclk edges.
// Backpressure: none, samples every cycle.
module sync_r2w #(
  parameter int W = fifo_pkg::ADDR_WIDTH_DFLT + 1
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] rptr,
  output logic [W-1:0] wq2_rptr
);
  logic [W-1:0] rq1;

  // Two back-to-back stages; rptr is Gray so at most one bit is in flight.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rq1      <= '0;
      wq2_rptr <= '0;
    end else begin
      rq1      <= rptr;
      wq2_rptr <= rq1;
    end
  end
endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag controller: address, enable, Gray wptr, full/almost-full/level/overflow.
// Latency: accepted write reflected on the same edge; rptr changes reach the flags after 3 wclk edges.
// Backpressure: writes while wfull are dropped (wen=0) and latch the sticky wovf flag.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int AF_MARGIN  = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_wptr_full_if.slave     wif
);
  localparam int A     = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_nx;
  logic [PW-1:0] wgray_nx;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] fill_nx;
  logic          wen;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wlevel_q;
  logic          wovf_q;

  sync_r2w #(.W(PW)) u_sync_r2w (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (wif.rptr),
    .wq2_rptr (rq2)
  );

  // Next pointer, its Gray form and the fill seen against the synchronised read pointer.
  always_comb begin
    wen      = wif.winc & ~wfull_q;
    wbin_nx  = wbin + PW'(wen);
    wgray_nx = PW'(bin2gray(gword_t'(wbin_nx)));
    rbin     = PW'(gray2bin(gword_t'(rq2)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp = {~rq2[A:A-1], rq2[A-2:0]};
    fill_nx  = wbin_nx - rbin;
  end

  // Pointer and flag registers, all updated on the edge that accepts the write.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
    end else begin
      wbin           <= wbin_nx;
      wptr_q         <= wgray_nx;
      wfull_q        <= (wgray_nx == full_cmp);
      walmost_full_q <= (fill_nx >= PW'(DEPTH - AF_MARGIN));
      wlevel_q       <= fill_nx;
    end
  end

  // Sticky overflow; a blocked write in the same cycle as a clear keeps it set.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else if (wif.winc && wfull_q) begin
      wovf_q <= 1'b1;
    end else if (wif.wovf_clr) begin
      wovf_q <= 1'b0;
    end
  end

  assign wif.waddr        = wbin[A-1:0];
  assign wif.wen          = wen;
  assign wif.wptr         = wptr_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = walmost_full_q;
  assign wif.wlevel       = wlevel_q;
  assign wif.wovf         = wovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for the write-side pointer/flag controller (ADDR_WIDTH=4, AF_MARGIN=2).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: exercised through full, blocked writes and the overflow flag.
module tb_fifo_wptr_full;
  logic wclk;
  logic wrst_n;
  int   vectors;
  int   fails;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) wif ();

  fifo_wptr_full #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wif    (wif.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  logic [4:0] prev;
  int wb;

  initial begin
    vectors = 0;
    fails   = 0;
    wrst_n  = 1'b0;
    wif.winc     = 1'b0;
    wif.wovf_clr = 1'b0;
    wif.rptr     = '0;
    #3;
    chk("rst_wptr",  32'(wif.wptr),  0);
    chk("rst_wlevel",32'(wif.wlevel),0);
    chk("rst_wfull", 32'(wif.wfull), 0);
    chk("rst_wen",   32'(wif.wen),   0);
    tick();
    wrst_n = 1'b1;
    tick();

    // Fill 16 words with rptr at 0.
    for (int i = 1; i <= 16; i++) begin
      wif.winc = 1'b1;
      #1;
      chk($sformatf("fill_wen_%0d", i), 32'(wif.wen), 1);
      tick();
      chk($sformatf("fill_lvl_%0d", i), 32'(wif.wlevel), 32'(i));
      chk($sformatf("fill_af_%0d", i),  32'(wif.walmost_full), (i >= 14) ? 1 : 0);
      chk($sformatf("fill_full_%0d", i),32'(wif.wfull), (i == 16) ? 1 : 0);
      chk($sformatf("fill_wptr_%0d", i),32'(wif.wptr), 32'(g5(i)));
    end
    chk("full_wptr_11000", 32'(wif.wptr),  32'h18);
    chk("full_waddr_0",    32'(wif.waddr), 0);

    // Blocked writes while full.
    chk("blk_wen", 32'(wif.wen), 0);
    tick();
    chk("blk_wptr1", 32'(wif.wptr), 32'h18);
    chk("blk_ovf1",  32'(wif.wovf), 1);
    tick();
    chk("blk_wptr2", 32'(wif.wptr), 32'h18);
    chk("blk_ovf2",  32'(wif.wovf), 1);
    wif.winc = 1'b0;
    wif.wovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(wif.wovf), 0);
    wif.winc = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(wif.wovf), 1);
    wif.winc = 1'b0;
    wif.wovf_clr = 1'b0;

    // Read of 4 words arrives: flags move exactly 3 edges later.
    wif.rptr = 5'b00110;
    tick();
    chk("rd_full_e1", 32'(wif.wfull), 1);
    tick();
    chk("rd_full_e2", 32'(wif.wfull), 1);
    chk("rd_lvl_e2",  32'(wif.wlevel), 16);
    tick();
    chk("rd_full_e3", 32'(wif.wfull), 0);
    chk("rd_lvl_e3",  32'(wif.wlevel), 12);
    chk("rd_af_e3",   32'(wif.walmost_full), 0);

    // Asynchronous reset mid-cycle, checked before the next edge.
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_wptr",  32'(wif.wptr),  0);
    chk("arst_waddr", 32'(wif.waddr), 0);
    chk("arst_wfull", 32'(wif.wfull), 0);
    chk("arst_wlevel",32'(wif.wlevel),0);
    chk("arst_wovf",  32'(wif.wovf),  0);
    wif.rptr = '0;
    tick();
    wrst_n = 1'b1;
    tick();

    // Wrap-around with the read side following the writer.
    wb   = 0;
    prev = wif.wptr;
    for (int i = 1; i <= 40; i++) begin
      wif.winc = 1'b1;
      wif.rptr = g5(wb);
      tick();
      wb++;
      chk($sformatf("wrap_wptr_%0d", i), 32'(wif.wptr), 32'(g5(wb)));
      chk($sformatf("wrap_1bit_%0d", i), 32'($countones(prev ^ wif.wptr)), 1);
      chk($sformatf("wrap_nofull_%0d", i), 32'(wif.wfull), 0);
      if (i >= 3) chk($sformatf("wrap_lvl_%0d", i), 32'(wif.wlevel), 3);
      prev = wif.wptr;
    end
    chk("wrap_waddr", 32'(wif.waddr), 8);

    // Let rq2 settle at read pointer 7, then top up to 15 words.
    wif.winc = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_lvl1", 32'(wif.wlevel), 1);
    wif.winc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("pre_lvl15", 32'(wif.wlevel), 15);
    chk("pre_full0", 32'(wif.wfull), 0);
    chk("pre_af",    32'(wif.walmost_full), 1);

    // Write and read on the same cycle at level 15.
    wif.rptr = g5(8);
    #1;
    chk("sim_wen", 32'(wif.wen), 1);
    tick();
    wif.winc = 1'b0;
    chk("sim_full_e0", 32'(wif.wfull), 1);
    chk("sim_lvl_e0",  32'(wif.wlevel), 16);
    chk("sim_wptr_e0", 32'(wif.wptr), 32'(g5(23)));
    tick();
    chk("sim_full_e1", 32'(wif.wfull), 1);
    tick();
    chk("sim_full_e2", 32'(wif.wfull), 0);
    chk("sim_lvl_e2",  32'(wif.wlevel), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
